// File: rtl/triangle_assemble.sv
// Collects a vertex stream into triangles of three, buffers them in a small FIFO
// and presents them first-word-fall-through over a valid/ready handshake.
module triangle_assemble #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   valid_in,
  input  logic [3:0][31:0]       vertex_in,
  input  logic                   ready_in,
  output logic                   valid_out,
  output logic [2:0][3:0][31:0]  triangle_out,
  output logic [CW-1:0]          count_out,
  output logic                   overflow_out
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [1:0]            r_idx;
  logic [3:0][31:0]      r_slot0;
  logic [3:0][31:0]      r_slot1;
  logic [2:0][3:0][31:0] r_mem [DEPTH];
  logic [AW-1:0]         r_rd_ptr;
  logic [AW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;

  logic w_push;
  logic w_pop;
  logic w_push_ok;

  assign w_push    = valid_in && (r_idx == 2'd2);
  assign w_pop     = (r_count != '0) && ready_in;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push_ok = w_push && ((r_count < CW'(DEPTH)) || w_pop);

  // Slot index: advances on every valid vertex, wraps after the third
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_idx <= 2'd0;
    end else if (valid_in) begin
      r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
    end
  end

  // Partial-triangle storage; contents are meaningless once r_idx is reset
  always_ff @(posedge clk_in) begin
    if (valid_in && (r_idx == 2'd0)) begin
      r_slot0 <= vertex_in;
    end
    if (valid_in && (r_idx == 2'd1)) begin
      r_slot1 <= vertex_in;
    end
  end

  // Third vertex bypasses its slot and goes straight into the FIFO entry
  always_ff @(posedge clk_in) begin
    if (!rst_in && w_push_ok) begin
      r_mem[r_wr_ptr] <= {vertex_in, r_slot1, r_slot0};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign valid_out    = (r_count != '0);
  assign triangle_out = r_mem[r_rd_ptr];
  assign count_out    = r_count;
  assign overflow_out = r_overflow;

endmodule

// File: tb/tb_triangle_assemble.sv
// Self-checking bench for triangle_assemble: vector table for ordinary triangles,
// hand-written sequences for fill, overflow, full pop/push and mid-triangle reset.
module tb_triangle_assemble;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                  clk_in = 1'b0;
  logic                  rst_in;
  logic                  valid_in;
  logic [3:0][31:0]      vertex_in;
  logic                  ready_in;
  logic                  valid_out;
  logic [2:0][3:0][31:0] triangle_out;
  logic [CW-1:0]         count_out;
  logic                  overflow_out;

  triangle_assemble #(.DEPTH(DEPTH)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .valid_in     (valid_in),
    .vertex_in    (vertex_in),
    .ready_in     (ready_in),
    .valid_out    (valid_out),
    .triangle_out (triangle_out),
    .count_out    (count_out),
    .overflow_out (overflow_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] c;
    int           g0;
    int           g1;
    logic [383:0] exp;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [383:0] sb_q[$];

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Every handshake the DUT completes is checked against the scoreboard head
  always @(negedge clk_in) begin
    if (!rst_in && valid_out && ready_in) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop got=%0h want=none", triangle_out);
      end else begin
        chk("pop_data", 384'(triangle_out), sb_q.pop_front());
      end
    end
  end

  function automatic logic [127:0] mk(input int unsigned k);
    return {32'h3F800000 + k, 32'hBF000000 + (k << 8), 32'h40490FDB ^ k, 32'hDEAD0000 | k};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic send(input logic [127:0] v);
    valid_in  = 1'b1;
    vertex_in = v;
    @(posedge clk_in);
    #1;
    valid_in  = 1'b0;
  endtask

  task automatic send_tri(input logic [127:0] a, b, c, input bit exp_accept);
    send(a);
    send(b);
    if (exp_accept) sb_q.push_back({c, b, a});
    send(c);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget;
    ready_in = 1'b1;
    budget = 0;
    while (count_out != '0 && budget < 50) begin
      idle(1);
      budget++;
    end
    chk({name, "_drain_in_time"}, 384'(budget < 50), 384'(1));
    idle(1);
    chk({name, "_sb_empty"}, 384'(sb_q.size()), 384'(0));
    ready_in = 1'b0;
  endtask

  localparam logic [127:0] VA = 128'h3F800000_3F687FCC_3E5C28F6_3F25E354;
  localparam logic [127:0] VB = 128'h3F800000_3F687FCC_3E5C28F6_BEFEF9DB;
  localparam logic [127:0] VC = 128'h3F800000_3F687FCC_3E5C28F6_3EFB7E91;

  vec_t tbl[4];
  logic [383:0] t1;

  initial begin
    rst_in    = 1'b1;
    valid_in  = 1'b0;
    vertex_in = '0;
    ready_in  = 1'b0;
    tbl[0] = '{a: VA, b: VB, c: VC, g0: 0, g1: 0, exp: {VC, VB, VA}};
    tbl[1] = '{a: VA, b: VB, c: VC, g0: 1, g1: 3, exp: {VC, VB, VA}};
    tbl[2] = '{a: mk(7), b: mk(8), c: mk(9), g0: 2, g1: 0, exp: {mk(9), mk(8), mk(7)}};
    tbl[3] = '{a: mk(20), b: mk(21), c: mk(22), g0: 0, g1: 5, exp: {mk(22), mk(21), mk(20)}};

    idle(2);
    rst_in = 1'b0;
    chk("rst_valid", 384'(valid_out), 384'(0));
    chk("rst_count", 384'(count_out), 384'(0));
    chk("rst_ovf", 384'(overflow_out), 384'(0));

    // Ordinary triangles, ready held high
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].a);
      idle(tbl[i].g0);
      chk("no_early_a", 384'(valid_out), 384'(0));
      send(tbl[i].b);
      idle(tbl[i].g1);
      chk("no_early_b", 384'(valid_out), 384'(0));
      sb_q.push_back(tbl[i].exp);
      send(tbl[i].c);
      chk("lat_valid", 384'(valid_out), 384'(1));
      chk("lat_count", 384'(count_out), 384'(1));
      idle(1);
      chk("one_cycle_valid", 384'(valid_out), 384'(0));
      chk("count_back_0", 384'(count_out), 384'(0));
    end
    chk("tbl_sb_empty", 384'(sb_q.size()), 384'(0));

    // Fill under backpressure
    ready_in = 1'b0;
    t1 = {mk(102), mk(101), mk(100)};
    for (int k = 0; k < 4; k++) begin
      send_tri(mk(100 + 3 * k), mk(101 + 3 * k), mk(102 + 3 * k), 1'b1);
      chk("fill_count", 384'(count_out), 384'(k + 1));
      chk("fill_ovf", 384'(overflow_out), 384'(0));
      chk("fill_head", 384'(triangle_out), t1);
    end

    // Fifth triangle is dropped
    send_tri(mk(200), mk(201), mk(202), 1'b0);
    chk("ovf_count", 384'(count_out), 384'(4));
    chk("ovf_flag", 384'(overflow_out), 384'(1));
    idle(3);
    chk("ovf_sticky", 384'(overflow_out), 384'(1));
    chk("ovf_head", 384'(triangle_out), t1);
    drain("ovf");
    chk("ovf_sticky_after_drain", 384'(overflow_out), 384'(1));

    // Full FIFO with a pop in the same cycle as the push
    do_reset();
    chk("rst2_ovf", 384'(overflow_out), 384'(0));
    chk("rst2_count", 384'(count_out), 384'(0));
    for (int k = 0; k < 4; k++) begin
      send_tri(mk(300 + 3 * k), mk(301 + 3 * k), mk(302 + 3 * k), 1'b1);
    end
    chk("full_count", 384'(count_out), 384'(4));
    send(mk(400));
    send(mk(401));
    ready_in = 1'b1;
    sb_q.push_back({mk(402), mk(401), mk(400)});
    send(mk(402));
    ready_in = 1'b0;
    chk("pp_count", 384'(count_out), 384'(4));
    chk("pp_ovf", 384'(overflow_out), 384'(0));
    drain("pp");
    chk("pp_ovf_end", 384'(overflow_out), 384'(0));

    // Reset discards a partial triangle
    ready_in = 1'b1;
    send(mk(500));
    send(mk(501));
    do_reset();
    chk("midrst_count", 384'(count_out), 384'(0));
    chk("midrst_valid", 384'(valid_out), 384'(0));
    send_tri(mk(600), mk(601), mk(602), 1'b1);
    chk("midrst_valid_after", 384'(valid_out), 384'(1));
    idle(3);
    chk("midrst_sb_empty", 384'(sb_q.size()), 384'(0));
    chk("midrst_count_end", 384'(count_out), 384'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
